arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload width per channel.
REQ-003 SHALL have parameter ARB_MODE, default ARB_RR: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
REQ-004 SHALL define localparam SELECT_BITS = $clog2(NUM_INPUTS).
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port i_valid, input, NUM_INPUTS bits: per-channel request.
REQ-008 SHALL have port i_data_bus, input, NUM_INPUTS*DATA_WIDTH bits: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port o_ready, output, NUM_INPUTS bits: per-channel accept, one-hot or zero.
REQ-010 SHALL have port o_valid, output, 1 bit: output register holds a beat.
REQ-011 SHALL have port o_data, output, DATA_WIDTH bits: registered payload.
REQ-012 SHALL have port o_select, output, SELECT_BITS bits: index of the channel that supplied o_data.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream accept.

Function
REQ-014 SHALL transfer on input channel k when i_valid[k] and o_ready[k] are both high in the same cycle, and on the output when o_valid and i_ready are both high.
REQ-015 SHALL define load_en = !o_valid || i_ready (output slot empty or draining this cycle).
REQ-016 SHALL drive o_ready = grant & {NUM_INPUTS{load_en}}, combinationally from i_valid, pointer and load_en; o_ready SHALL NOT depend on i_data_bus.
REQ-017 SHALL, in ARB_FIXED, grant the lowest-indexed asserted i_valid.
REQ-018 SHALL, in ARB_RR, grant the first asserted i_valid at or above pointer rr_ptr, searching upward and wrapping from NUM_INPUTS-1 to 0.
REQ-019 SHALL update rr_ptr to (granted index + 1) mod NUM_INPUTS only on an input transfer; a grant of NUM_INPUTS-1 SHALL set rr_ptr to 0.
REQ-020 SHALL leave rr_ptr unchanged when no input transfer occurs (no valid, or stalled).
REQ-021 SHALL, on an input transfer, load o_data and o_select from the granted channel and set o_valid=1 on the next edge (latency 1 cycle).
REQ-022 SHALL clear o_valid on an output transfer with no simultaneous input transfer.
REQ-023 SHALL handle simultaneous output and input transfers in one cycle by replacing the beat, giving full throughput of 1 beat/cycle.
REQ-024 SHALL hold o_data and o_select stable while o_valid && !i_ready (stall), with all o_ready low.
REQ-025 SHALL emit o_ready=0 when i_valid=0, and keep the output register unchanged apart from REQ-022.

Reset
REQ-026 SHALL, when i_rst_n=0 at a rising edge, set o_valid=0, o_data=0, o_select=0 and rr_ptr=0, overriding any simultaneous transfer.
REQ-027 SHALL drive o_ready to all zeros during reset, and SHALL discard a beat held mid-stall at reset.

Structure
REQ-028 SHALL place the arb_mode_e enum (ARB_RR, ARB_FIXED) in shared package mux_pkg.
REQ-029 SHALL implement arbitration in sub-module rr_arbiter (request, pointer, mode -> one-hot grant plus index); the datapath select SHALL use the index with the indexed part-select.

Verification
REQ-030 SHALL cover reset (N=4, W=8): hold i_rst_n=0 with i_valid=4'b1111 -> o_valid=0, o_ready=0, o_data=0.
REQ-031 SHALL cover round-robin rotation: ARB_RR, i_valid=4'b1111, data {DD,CC,BB,AA}, i_ready=1 -> o_select 0,1,2,3,0 on successive cycles, o_data AA,BB,CC,DD,AA, with the wrap after 3.
REQ-032 SHALL cover the stall: o_valid=1 with o_data=BB, drop i_ready for 3 cycles -> o_data=BB and o_select=1 held, o_ready=0000, rr_ptr unchanged.
REQ-033 SHALL cover fixed priority: ARB_FIXED, i_valid=4'b1010 -> grant channel 1 every cycle while held; channel 3 is never granted.
REQ-034 SHALL cover the sparse skip: ARB_RR, rr_ptr=2, i_valid=4'b0001 -> grant 0, then rr_ptr=1.
REQ-035 SHALL cover reset mid-stall: o_valid=1, i_ready=0, pulse i_rst_n=0 for one cycle -> o_valid=0 next cycle; first grant after reset comes from channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and helpers for the arbitrated N:1 register
//                mux (arb_mux) and its arbiter (rr_arbiter).
//                  arb_mode_e  - arbitration policy selector
//                  wrap_next() - modulo-N increment used for the RR pointer
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Arbitration policy. ARB_RR rotates priority after every accepted
    // beat; ARB_FIXED always prefers the lowest-indexed requester.
    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Smallest and largest supported channel counts.
    localparam int MIN_INPUTS = 2;
    localparam int MAX_INPUTS = 16;

    // (idx + 1) mod n, written as a compare so no divider is inferred.
    function automatic int unsigned wrap_next(input int unsigned idx,
                                              input int unsigned n);
        int unsigned nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return nxt;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational request arbiter. Searches the request
//                vector upward starting at a base index and wrapping from
//                NUM_INPUTS-1 to 0; the first asserted request wins.
//                In ARB_FIXED the base is forced to 0 (lowest index wins),
//                in ARB_RR the base is the caller's rotating pointer.
//  Ports       :
//      i_req        [NUM_INPUTS-1:0]  per-channel request
//      i_ptr        [SELECT_BITS-1:0] round-robin start pointer
//      i_mode       arb_mode_e        arbitration policy
//      o_grant      [NUM_INPUTS-1:0]  one-hot grant, zero when no request
//      o_grant_idx  [SELECT_BITS-1:0] binary index of the granted channel
//      o_grant_vld  1 bit             some request was granted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_INPUTS  = 4,
    localparam int SELECT_BITS = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0]  i_req,
    input  logic [SELECT_BITS-1:0] i_ptr,
    input  arb_mode_e              i_mode,
    output logic [NUM_INPUTS-1:0]  o_grant,
    output logic [SELECT_BITS-1:0] o_grant_idx,
    output logic                   o_grant_vld
);

    logic [SELECT_BITS-1:0] w_base;
    logic [SELECT_BITS-1:0] w_cand [NUM_INPUTS];

    assign w_base = (i_mode == ARB_FIXED) ? '0 : i_ptr;

    // Candidate g is the channel visited g steps after the base. The base is
    // always < NUM_INPUTS, so a single conditional subtract wraps it.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cand
        logic [SELECT_BITS:0] w_sum;
        assign w_sum       = {1'b0, w_base} + (SELECT_BITS+1)'(g);
        assign w_cand[g]   = (w_sum >= (SELECT_BITS+1)'(NUM_INPUTS))
                           ? SELECT_BITS'(w_sum - (SELECT_BITS+1)'(NUM_INPUTS))
                           : SELECT_BITS'(w_sum);
    end

    // Walk the candidates in search order and keep the first hit.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            if (!o_grant_vld && i_req[w_cand[off]]) begin
                o_grant_vld          = 1'b1;
                o_grant_idx          = w_cand[off];
                o_grant[w_cand[off]] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : N-to-1 arbitrated multiplexer with a single registered
//                output slot and valid/ready handshakes on both sides.
//                The arbiter picks one requesting channel; its payload is
//                captured into the output register whenever that register is
//                empty or being drained in the same cycle, so a continuously
//                ready sink sees one beat per cycle.
//  Ports       :
//      i_clk       1 bit                       clock, rising edge
//      i_rst_n     1 bit                       synchronous active-low reset
//      i_valid     [NUM_INPUTS-1:0]            per-channel request
//      i_data_bus  [NUM_INPUTS*DATA_WIDTH-1:0] channel k at [k*W +: W]
//      o_ready     [NUM_INPUTS-1:0]            per-channel accept (one-hot/0)
//      o_valid     1 bit                       output register holds a beat
//      o_data      [DATA_WIDTH-1:0]            registered payload
//      o_select    [SELECT_BITS-1:0]           source channel of o_data
//      i_ready     1 bit                       downstream accept
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import mux_pkg::*;
#(
    parameter  int        NUM_INPUTS  = 4,
    parameter  int        DATA_WIDTH  = 8,
    parameter  arb_mode_e ARB_MODE    = ARB_RR,
    localparam int        SELECT_BITS = $clog2(NUM_INPUTS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
    output logic [NUM_INPUTS-1:0]            o_ready,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [SELECT_BITS-1:0]           o_select,
    input  logic                             i_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]  data_q,   data_d;
    logic [SELECT_BITS-1:0] select_q, select_d;
    logic [SELECT_BITS-1:0] rr_ptr_q, rr_ptr_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0]  w_grant;
    logic [SELECT_BITS-1:0] w_grant_idx;
    logic                   w_grant_vld;
    logic                   w_load_en;
    logic                   w_accept;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_arbiter (
        .i_req       (i_valid),
        .i_ptr       (rr_ptr_q),
        .i_mode      (ARB_MODE),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // The slot can take a new beat when it is empty or draining now.
    assign w_load_en = !valid_q || i_ready;

    // Reset gates the accept so no upstream beat is consumed while the
    // register is being forced to its reset value.
    assign w_accept  = w_grant_vld && w_load_en && i_rst_n;
    assign o_ready   = w_accept ? w_grant : '0;

    assign w_sel_data = i_data_bus[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        select_d = select_q;
        rr_ptr_d = rr_ptr_q;
        if (w_accept) begin
            // An accept while draining simply replaces the beat.
            valid_d  = 1'b1;
            data_d   = w_sel_data;
            select_d = w_grant_idx;
            rr_ptr_d = SELECT_BITS'(wrap_next(int'(w_grant_idx),
                                              NUM_INPUTS));
        end else if (valid_q && i_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            select_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            select_q <= select_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_select = select_q;

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux. Two instances (round-robin
//                and fixed priority) share one set of stimulus; a behavioural
//                model of each is compared against the DUT every cycle, and
//                a set of directed scenarios pins literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;
    import mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data_bus;
    logic        rdy_dn;

    logic [3:0]  rr_ready, fx_ready;
    logic        rr_valid, fx_valid;
    logic [7:0]  rr_data,  fx_data;
    logic [1:0]  rr_sel,   fx_sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state, index 0 = round-robin, 1 = fixed
    int         m_ptr [2];
    bit         m_ov  [2];
    logic [7:0] m_od  [2];
    logic [1:0] m_os  [2];

    always #5 clk = ~clk;

    arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(ARB_RR)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data_bus(data_bus),
        .o_ready(rr_ready), .o_valid(rr_valid), .o_data(rr_data),
        .o_select(rr_sel), .i_ready(rdy_dn)
    );

    arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(ARB_FIXED)) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data_bus(data_bus),
        .o_ready(fx_ready), .o_valid(fx_valid), .o_data(fx_data),
        .o_select(fx_sel), .i_ready(rdy_dn)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester at or above start, wrapping; -1 when none.
    function automatic int exp_grant(input logic [3:0] v, input int start);
        int c;
        for (int off = 0; off < 4; off++) begin
            c = (start + off) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int model_start(input int m);
        return (m == 1) ? 0 : m_ptr[m];
    endfunction

    // ------------------------------------------------------------------
    // Reference model: advances on every rising edge
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            automatic int g  = exp_grant(valid, model_start(m));
            automatic bit le = !m_ov[m] || rdy_dn;
            if (!rst_n) begin
                m_ov[m]  <= 1'b0;
                m_od[m]  <= 8'h00;
                m_os[m]  <= 2'd0;
                m_ptr[m] <= 0;
            end else if (g >= 0 && le) begin
                m_ov[m]  <= 1'b1;
                m_od[m]  <= data_bus[g*8 +: 8];
                m_os[m]  <= 2'(g);
                m_ptr[m] <= (g + 1) % 4;
            end else if (m_ov[m] && rdy_dn) begin
                m_ov[m]  <= 1'b0;
            end
        end
    end

    task automatic cmp(input int m, input logic [3:0] rdy, input logic v,
                       input logic [7:0] d, input logic [1:0] s);
        int         g;
        logic [3:0] er;
        string      p;
        p  = (m == 1) ? "fx" : "rr";
        g  = exp_grant(valid, model_start(m));
        er = (rst_n && g >= 0 && (!m_ov[m] || rdy_dn)) ? 4'(1 << g) : 4'b0000;
        chk({p, ".o_ready"},  {28'd0, rdy}, {28'd0, er});
        chk({p, ".o_valid"},  {31'd0, v},   {31'd0, m_ov[m]});
        chk({p, ".o_data"},   {24'd0, d},   {24'd0, m_od[m]});
        chk({p, ".o_select"}, {30'd0, s},   {30'd0, m_os[m]});
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, rr_ready, rr_valid, rr_data, rr_sel);
            cmp(1, fx_ready, fx_valid, fx_data, fx_sel);
            chk("rr.rr_ptr", {30'd0, dut_rr.rr_ptr_q}, 32'(m_ptr[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end by t=200000");
        $fatal(1, "timeout");
    end

    logic [7:0] rot_exp [5];

    initial begin
        rot_exp[0] = 8'hAA; rot_exp[1] = 8'hBB; rot_exp[2] = 8'hCC;
        rot_exp[3] = 8'hDD; rot_exp[4] = 8'hAA;

        // Reset with every channel requesting
        rst_n    = 1'b0;
        valid    = 4'b1111;
        data_bus = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rdy_dn   = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        chk("reset.o_valid", {31'd0, rr_valid}, 32'd0);
        chk("reset.o_ready", {28'd0, rr_ready}, 32'd0);
        chk("reset.o_data",  {24'd0, rr_data},  32'd0);
        chk("reset.fx_ready", {28'd0, fx_ready}, 32'd0);
        step();

        // Round-robin rotation with wrap after channel 3
        rst_n = 1'b1;
        @(negedge clk);
        chk("rot.first_ready", {28'd0, rr_ready}, 32'b0001);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rot.sel%0d", k), {30'd0, rr_sel}, 32'(k % 4));
            chk($sformatf("rot.data%0d", k), {24'd0, rr_data}, {24'd0, rot_exp[k]});
            step();
        end

        // Stall holding BB from channel 1
        rdy_dn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall.o_data",   {24'd0, rr_data},  32'hBB);
            chk("stall.o_select", {30'd0, rr_sel},   32'd1);
            chk("stall.o_ready",  {28'd0, rr_ready}, 32'd0);
            chk("stall.rr_ptr",   {30'd0, dut_rr.rr_ptr_q}, 32'd2);
            step();
        end
        rdy_dn = 1'b1;
        @(negedge clk);
        chk("unstall.o_ready", {28'd0, rr_ready}, 32'b0100);
        step();
        @(negedge clk);
        chk("unstall.o_data", {24'd0, rr_data}, 32'hCC);

        // Fixed priority: channel 1 always beats channel 3
        valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fixed.o_ready", {28'd0, fx_ready}, 32'b0010);
            step();
        end
        @(negedge clk);
        chk("fixed.o_select", {30'd0, fx_sel},  32'd1);
        chk("fixed.o_data",   {24'd0, fx_data}, 32'hBB);

        // Sparse skip: pointer at 2, only channel 0 requesting
        valid = 4'b0010;
        step();
        valid = 4'b0001;
        @(negedge clk);
        chk("sparse.ptr_before", {30'd0, dut_rr.rr_ptr_q}, 32'd2);
        chk("sparse.o_ready",    {28'd0, rr_ready},        32'b0001);
        step();
        valid = 4'b0000;
        @(negedge clk);
        chk("sparse.ptr_after", {30'd0, dut_rr.rr_ptr_q}, 32'd1);
        chk("sparse.o_select",  {30'd0, rr_sel},          32'd0);
        chk("sparse.no_ready",  {28'd0, rr_ready},        32'd0);
        step();

        // Reset in the middle of a stall
        valid = 4'b1111;
        step();
        rdy_dn = 1'b0;
        @(negedge clk);
        chk("rststall.held", {31'd0, rr_valid}, 32'd1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rststall.ready_in_rst", {28'd0, rr_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rststall.o_valid",   {31'd0, rr_valid}, 32'd0);
        chk("rststall.first_rdy", {28'd0, rr_ready}, 32'b0001);
        step();
        @(negedge clk);
        chk("rststall.first_sel", {30'd0, rr_sel}, 32'd0);
        step();

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            valid    = 4'($urandom);
            data_bus = $urandom;
            rdy_dn   = ($urandom_range(0, 9) < 7);
            step();
        end

        rst_n = 1'b1;
        valid = 4'b0000;
        rdy_dn = 1'b1;
        step();
        step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arb_mux
`default_nettype wire
